// File: rtl/counter_sched_pkg.sv
// Shared types and defaults for the counter scheduler.
package counter_sched_pkg;

  localparam int unsigned NREQ_DEFAULT = 4;
  localparam int unsigned CW_DEFAULT   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/rr_picker.sv
// Round-robin first-set search: first req bit at or above ptr, wrapping to 0.
module rr_picker
  import counter_sched_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT,
  parameter int unsigned PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            valid,
  output logic [PW-1:0]   idx
);

  logic [PW-1:0] cand;

  // Walk from farthest to nearest so the bit closest to ptr wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      // NREQ is a power of two, so PW-bit wrap gives the modulo.
      cand = ptr + PW'(k);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/counter_scheduler.sv
// Time-shares one CW-bit up-counter among NREQ round-robin requesters.
module counter_scheduler
  import counter_sched_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT,
  parameter int unsigned CW   = CW_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] len,
  output logic [NREQ-1:0]    gnt,
  output logic               busy,
  output logic [CW-1:0]      count,
  output logic [NREQ-1:0]    done
);

  localparam int unsigned PW = $clog2(NREQ);

  state_e        state_q;
  logic [CW-1:0] len_q;
  logic [PW-1:0] idx_q;
  logic [PW-1:0] ptr_q;

  logic          pick_valid;
  logic [PW-1:0] pick_idx;
  logic [CW-1:0] len_sel;

  rr_picker #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_picker (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Length of the requester that would be granted this cycle.
  always_comb begin
    len_sel = len[int'(pick_idx) * int'(CW) +: CW];
  end

  // Scheduler FSM with registered grant, counter, done and busy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt     <= '0;
      done    <= '0;
      count   <= '0;
      busy    <= 1'b0;
      ptr_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done <= '0;
          if (pick_valid) begin
            state_q <= COUNT;
            gnt     <= NREQ'(1) << pick_idx;
            idx_q   <= pick_idx;
            len_q   <= len_sel;
            count   <= '0;
            busy    <= 1'b1;
          end
        end
        COUNT: begin
          if (!req[idx_q]) begin
            // Abort: owner withdrew, release without a done pulse.
            state_q <= IDLE;
            gnt     <= '0;
            count   <= '0;
            busy    <= 1'b0;
            ptr_q   <= idx_q + PW'(1);
          end else if (count == len_q) begin
            state_q <= DONE;
            gnt     <= '0;
            count   <= '0;
            done    <= NREQ'(1) << idx_q;
            ptr_q   <= idx_q + PW'(1);
          end else begin
            count <= count + CW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done    <= '0;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          gnt     <= '0;
          done    <= '0;
          count   <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/counter_scheduler.md
# counter_scheduler

Time-shares one CW-bit up-counter among NREQ requesters. Each requester asks for a count run of a given length. The scheduler grants the counter to one requester at a time in round-robin order, runs the count, and returns a one-cycle done pulse to that requester. It sits between client blocks and the counter datapath and owns all sequencing of that counter.

## Interface
Parameters:
- NREQ, 4: number of requesters; a power of two, at least 2.
- CW, 3: counter and length width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- req  in  NREQ  per-requester request level.
- len  in  NREQ*CW  per-requester run length, packed; requester i uses len[i*CW +: CW].
- gnt  out  NREQ  one-hot grant, registered.
- busy  out  1  high in COUNT and DONE.
- count  out  CW  shared counter value, registered.
- done  out  NREQ  one-cycle completion pulse, one-hot, registered.

## Operation
- Reset (rst=0 at a clock edge): state=IDLE, gnt=0, done=0, count=0, busy=0, round-robin pointer ptr=0. Reset wins over every other event, including mid-run.
- IDLE:
  - If any req bit is high, pick the first set bit searching from ptr upward, with wrap-around NREQ-1→0. Call it idx.
  - Next edge: gnt=onehot(idx), len_q=len[idx], count=0, go to COUNT.
  - If no req bit is high, stay in IDLE.
- COUNT:
  - count increments by 1 each cycle.
  - When count==len_q, the next edge enters DONE.
  - count stops at len_q, so the counter never wraps (len_q ≤ 2^CW−1).
- DONE, exactly one cycle:
  - done[idx]=1, gnt=0, count=0.
  - ptr=(idx+1) mod NREQ.
  - Next edge returns to IDLE.
- Abort: if req[idx] drops during COUNT, the next edge goes to IDLE. On that edge gnt=0, count=0, ptr=(idx+1) mod NREQ, and no done pulse is issued.
- len is sampled only at grant. Later changes to len are ignored until the next grant.
- req bits are ignored in COUNT and DONE, except the abort check on req[idx].
- A requester must drop req within the cycle after done. If req[idx] is still high when IDLE samples, it is granted again, subject to round-robin order.

## Timing
- Grant latency: req sampled high in IDLE at edge N gives gnt and count=0 at edge N+1.
- Run length: count shows 0..len_q over len_q+1 cycles in COUNT. done follows on the next cycle.
- Full turnaround for one requester: len_q+4 edges from req sampled high to the next possible grant. That is 1 grant edge, len_q+1 COUNT cycles, 1 DONE cycle and 1 IDLE sample.
- len=0: one COUNT cycle with count=0, then DONE.
- Simultaneous requests: only one grant. The others wait and are served in order after ptr.

## Structure
- Shared package counter_sched_pkg:
  - state typedef: IDLE=2'b00, COUNT=2'b01, DONE=2'b10.
  - default NREQ and CW constants.
- Sub-module rr_picker: combinational round-robin first-set search.
  - Inputs: req[NREQ], ptr[log2 NREQ].
  - Outputs: valid, idx.
- The FSM, counter, len_q, idx and ptr registers live in counter_scheduler.

## Test plan
- Reset mid-run: rst=0 while count=2 with gnt=0001. Next edge: gnt=0, count=0, done=0, busy=0, state IDLE. After release, req[0] is re-granted first because ptr=0.
- Single run: only req[2]=1 with len[2]=3. Expected:
  - gnt=0100 one edge after sampling.
  - count 0,1,2,3 on successive cycles.
  - Then done=0100 for one cycle with gnt=0.
  - busy high throughout.
- Round-robin: req=1111 held with all len=1. Grant order 0,1,2,3,0. Each grant gets 2 COUNT cycles, then 1 DONE, then 1 IDLE.
- Pointer wrap and fairness: ptr=3 after serving req[2], then req=1001. req[3] is granted before req[0].
- len boundaries:
  - len=0: one COUNT cycle at 0, then done.
  - len=7 (CW=3): count reaches 7, holds there for that one cycle, then DONE with count=0. No wrap to 0 inside COUNT.
- Abort: req[1] drops at count=1 with len=5. Next edge: gnt=0, count=0, no done pulse. The next grant goes to req[2] if it is requesting.
